// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined multi-channel bit-reduction engine.
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_PAR = 2'b00,
        MODE_MAJ = 2'b01,
        MODE_AND = 2'b10,
        MODE_OR  = 2'b11
    } mode_t;

    function automatic int pc_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/reduce_unit.sv
// Combinational reduction of one word to a single bit under a selectable mode.
module reduce_unit
    import reduce_pkg::*;
#(
    parameter int IN_W = 10
) (
    input  logic [IN_W-1:0] data,
    input  mode_t           mode,
    output logic            res
);

    localparam int PC_W = pc_w(IN_W);

    logic [PC_W-1:0] pc;
    logic [PC_W:0]   dbl;

    always_comb begin
        pc = '0;
        for (int i = 0; i < IN_W; i++) begin
            pc = pc + PC_W'(data[i]);
        end
    end

    // 2*popcount > IN_W, so an exact tie resolves to 0
    assign dbl = {pc, 1'b0};

    always_comb begin
        res = 1'b0;
        unique case (mode)
            MODE_PAR: res = ^data;
            MODE_MAJ: res = dbl > (PC_W + 1)'(IN_W);
            MODE_AND: res = &data;
            MODE_OR:  res = |data;
        endcase
    end

endmodule

// File: rtl/reduce_pipe_mc.sv
// Pipelined multi-channel reduction engine with valid/ready flow control
// and per-channel saturating counters of delivered 1-results.
module reduce_pipe_mc
    import reduce_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int CH    = 1,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*IN_W-1:0]  in_data,
    input  logic [1:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH-1:0]       out_data,
    output logic [CH*CNT_W-1:0] ones_cnt,
    input  logic                cnt_clr
);

    logic [CH-1:0]    res;
    logic             adv;
    logic             hs;
    logic [LAT-1:0]   vld;
    logic [CH-1:0]    dat [LAT];
    logic [CNT_W-1:0] cnt [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        reduce_unit #(
            .IN_W (IN_W)
        ) u_red (
            .data (in_data[c*IN_W +: IN_W]),
            .mode (mode_t'(in_mode)),
            .res  (res[c])
        );

        assign ones_cnt[c*CNT_W +: CNT_W] = cnt[c];
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign hs        = out_valid && out_ready;

    // Whole pipeline advances or holds together on one global enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else if (adv) begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? res : '0;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (cnt_clr) begin
                    cnt[c] <= '0;
                end else if (hs && out_data[c] && (cnt[c] != '1)) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reduce_pipe_mc.sv
// Directed scoreboard bench for reduce_pipe_mc (IN_W=10, CH=2, LAT=2, CNT_W=4).
module tb_reduce_pipe_mc;

    localparam int IN_W  = 10;
    localparam int CH    = 2;
    localparam int LAT   = 2;
    localparam int CNT_W = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [CH*IN_W-1:0]  in_data;
    logic [1:0]          in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [CH-1:0]       out_data;
    logic [CH*CNT_W-1:0] ones_cnt;
    logic                cnt_clr;

    int checks;
    int errors;

    logic [CH-1:0]    sb [$];
    logic [CNT_W-1:0] mcnt [CH];

    reduce_pipe_mc #(
        .IN_W  (IN_W),
        .CH    (CH),
        .LAT   (LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ones_cnt  (ones_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH-1:0] model(input logic [1:0] m,
                                            input logic [CH*IN_W-1:0] d);
        logic [CH-1:0]   r;
        logic [IN_W-1:0] w;
        int              n;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            w = d[c*IN_W +: IN_W];
            n = $countones(w);
            case (m)
                2'b00: r[c] = (n % 2) == 1;
                2'b01: r[c] = (2 * n) > IN_W;
                2'b10: r[c] = (n == IN_W);
                default: r[c] = (n != 0);
            endcase
        end
        return r;
    endfunction

    function automatic logic [CH*CNT_W-1:0] mpack();
        logic [CH*CNT_W-1:0] p;
        for (int c = 0; c < CH; c++) begin
            p[c*CNT_W +: CNT_W] = mcnt[c];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the upcoming edge at negedge, then step past posedge
    task automatic cyc();
        logic          acc;
        logic          hs;
        logic [CH-1:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        chk("cnt_model", ones_cnt, mpack());
        e = '0;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e);
            end
        end
        if (acc) sb.push_back(model(in_mode, in_data));
        for (int c = 0; c < CH; c++) begin
            if (cnt_clr) mcnt[c] = '0;
            else if (hs && e[c] && mcnt[c] != '1) mcnt[c] = mcnt[c] + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [CH*IN_W-1:0] d);
        logic done;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            done = in_ready;
            cyc();
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic flush_model();
        sb.delete();
        for (int c = 0; c < CH; c++) mcnt[c] = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        flush_model();
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_cnt", ones_cnt, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // Latency: output exactly LAT cycles after acceptance, one cycle wide
        send(2'b00, {10'h001, 10'h3FF});
        chk("lat_v_k", {63'd0, out_valid}, 64'd0);
        cyc();
        chk("lat_v_k1", {63'd0, out_valid}, 64'd1);
        chk("lat_data", out_data, 64'h2);
        cyc();
        chk("lat_v_k2", {63'd0, out_valid}, 64'd0);

        send(2'b01, {10'h01F, 10'h03F});
        send(2'b10, {10'h3FE, 10'h3FF});
        cyc();
        chk("and_data", out_data, 64'h1);
        cyc();

        // Backpressure
        out_ready = 1'b0;
        send(2'b11, {10'h000, 10'h001});
        send(2'b11, {10'h010, 10'h000});
        in_valid = 1'b1;
        in_mode  = 2'b11;
        in_data  = {10'h3FF, 10'h200};
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_data", out_data, 64'h1);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("rel_b_valid", {63'd0, out_valid}, 64'd1);
        chk("rel_b_data", out_data, 64'h2);
        cyc();
        chk("rel_c_valid", {63'd0, out_valid}, 64'd1);
        chk("rel_c_data", out_data, 64'h3);
        cyc();
        chk("rel_done", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Saturation
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(2'b11, {10'h000, 10'(i + 1)});
        end
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_cnt", ones_cnt, {4'd0, 4'd15});

        // Clear has priority over a same-cycle increment
        send(2'b11, {10'h000, 10'h001});
        chk("clr_pre_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        chk("clr_hs_valid", {63'd0, out_valid}, 64'd1);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("clr_cnt0", 64'(ones_cnt[CNT_W-1:0]), 64'd0);
        send(2'b11, {10'h001, 10'h001});
        cyc();
        cyc();
        chk("post_clr_cnt", ones_cnt, {4'd1, 4'd1});

        // Asynchronous reset with beats in flight
        out_ready = 1'b0;
        send(2'b11, {10'h001, 10'h001});
        send(2'b00, {10'h001, 10'h000});
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_data", out_data, 64'd0);
        chk("arst_cnt", ones_cnt, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        flush_model();
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        end

        // Mixed modes every beat, back to back
        send(2'b01, {10'h3F0, 10'h00F});
        send(2'b00, {10'h003, 10'h007});
        send(2'b10, {10'h000, 10'h3FF});
        for (int i = 0; i < 4; i++) cyc();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
